// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian request front-end.
// Holds the FSM state encoding and the wait-counter width and saturation value.
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVED  = 2'd2,
        HOLDOFF = 2'd3
    } ped_state_t;

    localparam int WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_SAT = 8'd255;

    function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
        return (v == WAIT_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchroniser, stable-level debounce and registered rising-edge pulse.
// Latency from raw rise to btn_press is 2 + DB_CYCLES + 1 cycles; no backpressure.
module btn_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_press
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1;
    logic            btn_sync;
    logic            btn_db;
    logic            btn_db_d1;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sync1    <= btn_raw;
            btn_sync <= sync1;
        end
    end

    // Any return to the accepted level restarts the count, so short glitches never get through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            btn_db <= 1'b0;
        end else if (btn_sync != btn_db) begin
            if (db_cnt == DB_LAST) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db_d1 <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            btn_db_d1 <= btn_db;
            btn_press <= btn_db & ~btn_db_d1;
        end
    end

endmodule

// File: rtl/ped_request_ctl.sv
// Pedestrian crossing request controller: latches a debounced press, holds ped_req until walk_ack, then holds off.
// Outputs registered, one cycle after the trigger; optional chirp output when PED_CHIRP_EN is defined.
module ped_request_ctl
    import ped_pkg::*;
#(
    parameter int DB_CYCLES      = 50000,
    parameter int DB_W           = 16,
    parameter int HOLDOFF_TICKS  = 10,
    parameter int MAX_WAIT_TICKS = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              btn_raw,
    input  logic              day_night,
    input  logic              walk_ack,
    input  logic              walk_active,
    output logic              ped_req,
    output logic              ped_urgent,
    output logic              wait_led,
    output logic [WAIT_W-1:0] wait_secs,
`ifdef PED_CHIRP_EN
    output logic              chirp,
`endif
    output logic              btn_press
);

    localparam int HOLD_W = (HOLDOFF_TICKS > 0) ? $clog2(HOLDOFF_TICKS + 1) : 1;
    localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(MAX_WAIT_TICKS);

    ped_state_t        state, state_n;
    logic [WAIT_W-1:0] wait_n;
    logic              led_n;
    logic              urgent_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_press (btn_press)
    );

    always_comb begin
        state_n  = state;
        wait_n   = wait_secs;
        led_n    = wait_led;
        urgent_n = ped_urgent;
        hold_n   = hold_cnt;

        if (!day_night) begin
            state_n = IDLE;
            hold_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_press) begin
                        state_n  = PENDING;
                        wait_n   = '0;
                        led_n    = 1'b1;
                        urgent_n = 1'b0;
                    end
                end
                PENDING: begin
                    // walk_ack outranks a coincident tick so the wait count clears.
                    if (walk_ack) begin
                        state_n = SERVED;
                    end else if (tick) begin
                        wait_n   = wait_sat_inc(wait_secs);
                        led_n    = ped_urgent ? ~wait_led : 1'b1;
                        urgent_n = (wait_n >= MAX_WAIT);
                    end
                end
                SERVED: begin
                    if (!walk_active) begin
                        if (HOLDOFF_TICKS == 0) begin
                            state_n = IDLE;
                        end else begin
                            state_n = HOLDOFF;
                            hold_n  = HOLD_W'(HOLDOFF_TICKS);
                        end
                    end
                end
                HOLDOFF: begin
                    if (tick) begin
                        hold_n = hold_cnt - 1'b1;
                        if (hold_n == '0) begin
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (state_n != PENDING) begin
            wait_n   = '0;
            led_n    = 1'b0;
            urgent_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            wait_secs  <= '0;
            wait_led   <= 1'b0;
            ped_urgent <= 1'b0;
            ped_req    <= 1'b0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_n;
            wait_secs  <= wait_n;
            wait_led   <= led_n;
            ped_urgent <= urgent_n;
            ped_req    <= (state_n == PENDING);
        end
    end

`ifdef PED_CHIRP_EN
    logic [1:0] chirp_ph, chirp_ph_n;
    logic       chirp_n;

    // Locator tone: high for the fourth tick period of every four while waiting.
    always_comb begin
        chirp_n    = 1'b0;
        chirp_ph_n = chirp_ph;
        if (state_n == PENDING) begin
            if (state != PENDING) begin
                chirp_ph_n = '0;
            end else if (tick) begin
                chirp_ph_n = chirp_ph + 1'b1;
            end
            chirp_n = (chirp_ph_n == 2'd3);
        end else if (state_n == SERVED && walk_active) begin
            if (state == SERVED) begin
                chirp_n = tick ? ~chirp : chirp;
            end
        end
        if (state_n != PENDING) begin
            chirp_ph_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chirp    <= 1'b0;
            chirp_ph <= '0;
        end else begin
            chirp    <= chirp_n;
            chirp_ph <= chirp_ph_n;
        end
    end
`endif

endmodule

// File: tb/tb_ped_request_ctl.sv
// Directed bench for ped_request_ctl with DB_CYCLES=4, HOLDOFF_TICKS=10, MAX_WAIT_TICKS=60.
// Inputs driven and outputs sampled 1 time unit after each rising clock edge.
module tb_ped_request_ctl;
    import ped_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       btn_raw;
    logic       day_night;
    logic       walk_ack;
    logic       walk_active;
    logic       ped_req;
    logic       ped_urgent;
    logic       wait_led;
    logic [7:0] wait_secs;
    logic       btn_press;
`ifdef PED_CHIRP_EN
    logic       chirp;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ped_request_ctl #(
        .DB_CYCLES      (4),
        .DB_W           (4),
        .HOLDOFF_TICKS  (10),
        .MAX_WAIT_TICKS (60)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .btn_raw     (btn_raw),
        .day_night   (day_night),
        .walk_ack    (walk_ack),
        .walk_active (walk_active),
        .ped_req     (ped_req),
        .ped_urgent  (ped_urgent),
        .wait_led    (wait_led),
        .wait_secs   (wait_secs),
`ifdef PED_CHIRP_EN
        .chirp       (chirp),
`endif
        .btn_press   (btn_press)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(1);
    endtask

    task automatic press_release();
        btn_raw = 1'b1;
        step(10);
        btn_raw = 1'b0;
        step(10);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; btn_raw = 1'b0; day_night = 1'b1;
        walk_ack = 1'b0; walk_active = 1'b0;
        step(2);
        n_checks++;
        if ({ped_req, ped_urgent, wait_led, wait_secs, btn_press} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b urg=%b led=%b secs=%0d press=%b, want all 0",
                     ped_req, ped_urgent, wait_led, wait_secs, btn_press);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_glitch();
        repeat (5) begin
            btn_raw = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step(1);
                n_checks++;
                if (btn_press !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_press: btn_press=%b, want 0", btn_press);
                end
            end
            btn_raw = 1'b0;
            step(3);
        end
        step(6);
        n_checks++;
        if (ped_req !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_req: ped_req=%b, want 0", ped_req);
        end
    endtask

    task automatic test_press();
        btn_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            n_checks++;
            if (btn_press !== (i == 7)) begin
                n_fail++;
                $display("FAIL press_pulse: cycle %0d btn_press=%b, want %b", i, btn_press, (i == 7));
            end
            n_checks++;
            if (ped_req !== (i >= 8)) begin
                n_fail++;
                $display("FAIL press_req: cycle %0d ped_req=%b, want %b", i, ped_req, (i >= 8));
            end
            if (i == 8) begin
                n_checks++;
                if (wait_secs !== 8'd0 || wait_led !== 1'b1) begin
                    n_fail++;
                    $display("FAIL press_wait: secs=%0d led=%b, want 0 and 1", wait_secs, wait_led);
                end
            end
        end
        btn_raw = 1'b0;
        step(10);
    endtask

    task automatic test_wait_urgent();
        for (int t = 1; t <= 300; t++) begin
            do_tick();
            if (t == 59) begin
                n_checks++;
                if (wait_secs !== 8'd59 || ped_urgent !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wait_59: secs=%0d urg=%b, want 59 and 0", wait_secs, ped_urgent);
                end
            end
            if (t == 60) begin
                n_checks++;
                if (wait_secs !== 8'd60 || ped_urgent !== 1'b1 || wait_led !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wait_60: secs=%0d urg=%b led=%b, want 60 1 1",
                             wait_secs, ped_urgent, wait_led);
                end
            end
            if (t == 61 || t == 62) begin
                n_checks++;
                if (wait_led !== (t == 62)) begin
                    n_fail++;
                    $display("FAIL led_blink: tick %0d led=%b, want %b", t, wait_led, (t == 62));
                end
            end
        end
        n_checks++;
        if (wait_secs !== 8'd255 || ped_urgent !== 1'b1 || ped_req !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_sat: secs=%0d urg=%b req=%b, want 255 1 1", wait_secs, ped_urgent, ped_req);
        end
    endtask

    task automatic test_ack_holdoff();
        walk_active = 1'b1;
        walk_ack = 1'b1;
        tick = 1'b1;
        step(1);
        walk_ack = 1'b0;
        tick = 1'b0;
        n_checks++;
        if ({ped_req, ped_urgent, wait_led} !== 3'b000 || wait_secs !== 8'd0 || dut.state !== SERVED) begin
            n_fail++;
            $display("FAIL ack_tick: req=%b urg=%b led=%b secs=%0d state=%0d, want 0 0 0 0 SERVED",
                     ped_req, ped_urgent, wait_led, wait_secs, dut.state);
        end
        step(3);
`ifdef PED_CHIRP_EN
        n_checks++;
        if (chirp !== 1'b0) begin
            n_fail++;
            $display("FAIL chirp_start: chirp=%b, want 0", chirp);
        end
        for (int k = 1; k <= 2; k++) begin
            do_tick();
            n_checks++;
            if (chirp !== (k == 1)) begin
                n_fail++;
                $display("FAIL chirp_toggle: tick %0d chirp=%b, want %b", k, chirp, (k == 1));
            end
        end
`endif
        n_checks++;
        if (dut.state !== SERVED || ped_req !== 1'b0) begin
            n_fail++;
            $display("FAIL served_hold: state=%0d req=%b, want SERVED 0", dut.state, ped_req);
        end
        walk_active = 1'b0;
        step(1);
        n_checks++;
        if (dut.state !== HOLDOFF) begin
            n_fail++;
            $display("FAIL enter_holdoff: state=%0d, want HOLDOFF", dut.state);
        end
        repeat (5) do_tick();
        press_release();
        n_checks++;
        if (ped_req !== 1'b0 || dut.state !== HOLDOFF) begin
            n_fail++;
            $display("FAIL holdoff_press: req=%b state=%0d, want 0 HOLDOFF", ped_req, dut.state);
        end
        repeat (4) do_tick();
        n_checks++;
        if (dut.state !== HOLDOFF) begin
            n_fail++;
            $display("FAIL holdoff_9: state=%0d, want HOLDOFF", dut.state);
        end
        do_tick();
        n_checks++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL holdoff_10: state=%0d, want IDLE", dut.state);
        end
        press_release();
        n_checks++;
        if (ped_req !== 1'b1) begin
            n_fail++;
            $display("FAIL repress: ped_req=%b, want 1", ped_req);
        end
    endtask

    task automatic test_night();
        repeat (2) do_tick();
        day_night = 1'b0;
        step(1);
        n_checks++;
        if ({ped_req, ped_urgent, wait_led} !== 3'b000 || wait_secs !== 8'd0) begin
            n_fail++;
            $display("FAIL night_clear: req=%b urg=%b led=%b secs=%0d, want all 0",
                     ped_req, ped_urgent, wait_led, wait_secs);
        end
        press_release();
        n_checks++;
        if (ped_req !== 1'b0) begin
            n_fail++;
            $display("FAIL night_press: ped_req=%b, want 0", ped_req);
        end
        day_night = 1'b1;
        step(3);
        n_checks++;
        if (ped_req !== 1'b0 || dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL day_phantom: req=%b state=%0d, want 0 IDLE", ped_req, dut.state);
        end
        btn_raw = 1'b1;
        step(7);
        n_checks++;
        if (btn_press !== 1'b1) begin
            n_fail++;
            $display("FAIL night_edge_press: btn_press=%b, want 1", btn_press);
        end
        day_night = 1'b0;
        step(1);
        day_night = 1'b1;
        btn_raw = 1'b0;
        n_checks++;
        if (ped_req !== 1'b0) begin
            n_fail++;
            $display("FAIL press_vs_night: ped_req=%b, want 0", ped_req);
        end
        step(10);
        n_checks++;
        if (ped_req !== 1'b0) begin
            n_fail++;
            $display("FAIL press_vs_night_late: ped_req=%b, want 0", ped_req);
        end
    endtask

    task automatic test_async_reset();
        press_release();
        do_tick();
        n_checks++;
        if (ped_req !== 1'b1 || wait_secs !== 8'd1 || wait_led !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: req=%b secs=%0d led=%b, want 1 1 1", ped_req, wait_secs, wait_led);
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ped_req, ped_urgent, wait_led, wait_secs, btn_press} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: req=%b urg=%b led=%b secs=%0d press=%b, want all 0",
                     ped_req, ped_urgent, wait_led, wait_secs, btn_press);
        end
        step(1);
        rst = 1'b0;
        step(2);
        n_checks++;
        if (ped_req !== 1'b0 || dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL post_reset: req=%b state=%0d, want 0 IDLE", ped_req, dut.state);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_wait_urgent();
        test_ack_holdoff();
        test_night();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
